ram_frame_reader: RTL and testbench

//  Read-side master for the 8-bit pixel RAM (registered rd_en/rd_addr, 2-cycle read latency).
//  On start, walks a WIDTH x HEIGHT window from base_addr, issues one RAM read per pixel and

---
 rtl/ram_frame_reader.sv | 215 +++++++++++++++++++++
 tb/tb_ram_frame_reader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_frame_reader.sv
// rtl/ram_frame_reader.sv - frame-window RAM read master with credit-limited pixel FIFO
// Build option: define RAM_FRAME_READER_LOOP_EN to rescan the frame continuously after one start.
module ram_frame_reader #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clock_i,
  input  logic                     reset_n_i,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        base_addr_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     rd_en_o,
  output logic [ADDR_W-1:0]        rd_addr_o,
  input  logic signed [DATA_W-1:0] rd_data_i,
  output logic                     pix_valid_o,
  input  logic                     pix_ready_i,
  output logic signed [DATA_W-1:0] pix_data_o,
  output logic                     pix_sof_o,
  output logic                     pix_eol_o
);

  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_e;

  // Per-read side information travelling alongside the RAM access.
  typedef struct packed {
    logic sof;
    logic eol;
    logic last;
  } tag_t;

  state_e              state_q;
  logic                busy_q, done_q;
  logic [ADDR_W-1:0]   base_q;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_en_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  tag_t                rd_tag_q, rd_tag_d;

  logic [RD_LAT-1:0]   pipe_v_q;
  tag_t                pipe_tag_q [RD_LAT];

  logic signed [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  tag_t                fifo_tag_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       cnt_q;
  // Occupancy = FIFO entries plus reads not yet written into the FIFO.
  logic [CW-1:0]       occ_q;

  logic                pop, push, starting, credit_ok, issue, last_x, last_px;
  logic [XW-1:0]       cur_x;
  logic [YW-1:0]       cur_y;
  logic [ADDR_W-1:0]   cur_addr, loop_base;
  tag_t                head_tag;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push        = pipe_v_q[RD_LAT-1];
  assign head_tag    = fifo_tag_q[rd_ptr_q];
  assign pix_valid_o = (cnt_q != '0);
  assign pix_data_o  = fifo_data_q[rd_ptr_q];
  assign pix_sof_o   = pix_valid_o & head_tag.sof;
  assign pix_eol_o   = pix_valid_o & head_tag.eol;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rd_en_o     = rd_en_q;
  assign rd_addr_o   = rd_addr_q;

  // Issue decision and next read cursor; a start in IDLE issues pixel 0 at once.
  always_comb begin
    pop       = pix_valid_o & pix_ready_i;
    starting  = (state_q == S_IDLE) & start_i;
    cur_x     = starting ? '0 : x_q;
    cur_y     = starting ? '0 : y_q;
    cur_addr  = starting ? base_addr_i : addr_q;
    loop_base = starting ? base_addr_i : base_q;
    last_x    = (cur_x == X_LAST);
    last_px   = last_x & (cur_y == Y_LAST);
    // A pop this cycle frees a slot for the read issued next cycle.
    credit_ok = (occ_q < CW'(FIFO_DEPTH)) | pop;
    issue     = (starting | (state_q == S_FETCH)) & credit_ok;
    rd_tag_d.sof  = (cur_x == '0) & (cur_y == '0);
    rd_tag_d.eol  = last_x;
    rd_tag_d.last = last_px;
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (issue) begin
      if (last_px) begin
        x_d    = '0;
        y_d    = '0;
        addr_d = loop_base;
      end else if (last_x) begin
        x_d    = '0;
        y_d    = cur_y + YW'(1);
        addr_d = cur_addr + ADDR_W'(1);
      end else begin
        x_d    = cur_x + XW'(1);
        y_d    = cur_y;
        addr_d = cur_addr + ADDR_W'(1);
      end
    end else if (starting) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = base_addr_i;
    end
  end

  // Frame sequencing FSM with read cursor and registered RAM/status outputs
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      base_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_tag_q  <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      rd_en_q <= issue;
      done_q  <= pop & head_tag.last;
      if (issue) begin
        rd_addr_q <= cur_addr;
        rd_tag_q  <= rd_tag_d;
      end
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            base_q <= base_addr_i;
            busy_q <= 1'b1;
`ifdef RAM_FRAME_READER_LOOP_EN
            state_q <= S_FETCH;
`else
            state_q <= (issue & last_px) ? S_DRAIN : S_FETCH;
`endif
          end
        end
        S_FETCH: begin
`ifdef RAM_FRAME_READER_LOOP_EN
          state_q <= S_FETCH;
`else
          if (issue & last_px) state_q <= S_DRAIN;
`endif
        end
        S_DRAIN: begin
          if (pop & head_tag.last) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Return-path tag shift matching the RAM read latency
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pipe_v_q <= '0;
      for (int k = 0; k < RD_LAT; k++) pipe_tag_q[k] <= '0;
    end else begin
      pipe_v_q[0]   <= rd_en_q;
      pipe_tag_q[0] <= rd_tag_q;
      for (int k = 1; k < RD_LAT; k++) begin
        pipe_v_q[k]   <= pipe_v_q[k-1];
        pipe_tag_q[k] <= pipe_tag_q[k-1];
      end
    end
  end

  // Return-data FIFO plus occupancy credit counter
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_tag_q[i]  <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= rd_data_i;
        fifo_tag_q[wr_ptr_q]  <= pipe_tag_q[RD_LAT-1];
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      occ_q <= occ_q + CW'(issue) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_ram_frame_reader.sv
// tb/tb_ram_frame_reader.sv - randomized self-checking bench for ram_frame_reader
module tb_ram_frame_reader;

  localparam int AW = 19, DW = 8, W = 4, H = 2, RL = 2, D = 4, NPIX = W * H;
`ifdef RAM_FRAME_READER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, pix_ready = 1'b0;
  logic [AW-1:0] base = '0;
  logic busy_o, done_o, rd_en_o, pix_valid_o, pix_sof_o, pix_eol_o;
  logic [AW-1:0] rd_addr_o;
  logic signed [DW-1:0] rd_data, pix_data_o;

  ram_frame_reader #(.ADDR_W(AW), .DATA_W(DW), .WIDTH(W), .HEIGHT(H),
                     .RD_LAT(RL), .FIFO_DEPTH(D)) dut (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(start_i), .base_addr_i(base),
    .busy_o(busy_o), .done_o(done_o), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
    .rd_data_i(rd_data), .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready),
    .pix_data_o(pix_data_o), .pix_sof_o(pix_sof_o), .pix_eol_o(pix_eol_o));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM: data for a read in cycle t appears in cycle t+RL; junk otherwise.
  logic [DW-1:0] ram_pipe [RL];
  always @(posedge clk) begin
    ram_pipe[0] <= rd_en_o ? rd_addr_o[7:0] : DW'($urandom);
    for (int k = 1; k < RL; k++) ram_pipe[k] <= ram_pipe[k-1];
  end
  assign rd_data = ram_pipe[RL-1];

  // 0: stalled, 1: always ready, 2: random ready
  int rdy_mode = 1;
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) pix_ready = 1'b0;
    else if (rdy_mode == 1) pix_ready = 1'b1;
    else pix_ready = ($urandom_range(0, 3) != 0);
  end

  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: expected read addresses and expected pixel stream.
  typedef struct packed {
    logic [7:0] d;
    logic sof;
    logic eol;
    logic last;
  } px_t;
  px_t pq[$];
  logic [AW-1:0] aq[$];
  logic [AW-1:0] frame_base = '0;
  bit busy_e = 0, done_e = 0, busy_now, hs_last, prev_stall = 0;
  logic [7:0] prev_d;
  logic prev_sof, prev_eol;
  int reads_out = 0;
  px_t e;

  // Logs for the hand-computed checks
  int rd_cnt = 0, done_cnt = 0, sof_cnt = 0, first_valid_cyc = -1, accept_cyc = -1;
  logic [7:0] log_pd[$];
  logic log_sof[$], log_eol[$];
  logic [AW-1:0] log_addr[$];
  int pix_at_done[$];

  task automatic push_frame(input logic [AW-1:0] b);
    logic [AW-1:0] a;
    px_t p;
    for (int i = 0; i < NPIX; i++) begin
      a = b + AW'(i);
      aq.push_back(a);
      p.d = a[7:0];
      p.sof = (i == 0);
      p.eol = ((i % W) == W - 1);
      p.last = (i == NPIX - 1);
      pq.push_back(p);
    end
  endtask

  task automatic clear_logs();
    rd_cnt = 0; done_cnt = 0; sof_cnt = 0; first_valid_cyc = -1; accept_cyc = -1;
    log_pd.delete(); log_sof.delete(); log_eol.delete(); log_addr.delete(); pix_at_done.delete();
  endtask

  // Per-cycle compare against the model, then advance the model one cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {busy_o, done_o, rd_en_o, rd_addr_o, pix_valid_o,
                            pix_data_o, pix_sof_o, pix_eol_o}, 64'd0);
      pq.delete(); aq.delete();
      busy_e = 0; done_e = 0; reads_out = 0; prev_stall = 0;
    end else begin
      chk("busy", busy_o, busy_e);
      chk("done", done_o, done_e);
      if (done_o) begin
        done_cnt++;
        pix_at_done.push_back(log_pd.size());
      end
      if (rd_en_o) begin
        rd_cnt++;
        log_addr.push_back(rd_addr_o);
        reads_out++;
        chk("read_expected", aq.size() != 0, 1);
        if (aq.size() != 0) chk("rd_addr", rd_addr_o, aq.pop_front());
        chk("credit_limit", reads_out <= D, 1);
      end
      if (prev_stall)
        chk("stall_hold", {pix_valid_o, pix_data_o, pix_sof_o, pix_eol_o},
            {1'b1, prev_d, prev_sof, prev_eol});
      if (pix_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (pix_valid_o) chk("valid_has_pixel", pq.size() != 0, 1);
      hs_last = 0;
      if (pix_valid_o && pix_ready && pq.size() != 0) begin
        e = pq.pop_front();
        chk("pixel", {pix_data_o, pix_sof_o, pix_eol_o}, {e.d, e.sof, e.eol});
        reads_out--;
        log_pd.push_back(pix_data_o);
        log_sof.push_back(pix_sof_o);
        log_eol.push_back(pix_eol_o);
        if (pix_sof_o) sof_cnt++;
        hs_last = e.last;
      end
      busy_now = busy_e;
      done_e = hs_last;
      if (hs_last) begin
        if (LOOP) push_frame(frame_base);
        else busy_e = 0;
      end
      if (start_i && !busy_now) begin
        busy_e = 1;
        frame_base = base;
        push_frame(base);
        if (LOOP) push_frame(base);
        accept_cyc = cyc;
      end
      prev_stall = pix_valid_o && !pix_ready;
      prev_d = pix_data_o;
      prev_sof = pix_sof_o;
      prev_eol = pix_eol_o;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    start_i = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    clear_logs();
  endtask

  task automatic pulse_start(input logic [AW-1:0] b);
    @(posedge clk); #1;
    start_i = 1;
    base = b;
    @(posedge clk); #1;
    start_i = 0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk); #1;
      if (done_o) break;
      n++;
    end
    chk("done_within_budget", n < budget, 1);
  endtask

  int seen, n;

  initial begin
    // Reset held with start asserted
    rst_n = 0; start_i = 1; base = 19'h01234; rdy_mode = 1;
    repeat (5) @(posedge clk);
    #1; start_i = 0;
    @(posedge clk); #1; rst_n = 1;
    repeat (3) @(posedge clk);
    chk("reset_no_read", rd_cnt, 0);
    chk("reset_idle", busy_o, 0);

    // Basic frame at 0x100, always ready
    do_reset();
    rdy_mode = 1;
    pulse_start(19'h00100);
    wait_done(100);
    chk("t2_latency", first_valid_cyc - accept_cyc, 4);
    chk("t2_logged", log_pd.size() >= 8, 1);
    chk("t2_dones", pix_at_done.size(), 1);
    if (pix_at_done.size() > 0) chk("t2_pix_at_done", pix_at_done[0], 8);
    for (int i = 0; i < 8; i++) begin
      if (i < log_pd.size()) begin
        chk("t2_data", log_pd[i], i);
        chk("t2_sof", log_sof[i], i == 0);
        chk("t2_eol", log_eol[i], (i == 3) || (i == 7));
      end
    end

    // Backpressure: no ready for 20 cycles
    do_reset();
    rdy_mode = 0;
    pulse_start(19'h02000);
    repeat (20) @(posedge clk);
    chk("t3_reads_stalled", rd_cnt, 4);
    chk("t3_none_accepted", log_pd.size(), 0);
    rdy_mode = 1;
    wait_done(100);
    if (pix_at_done.size() > 0) chk("t3_pix_at_done", pix_at_done[0], 8);

    // Address wrap at top of address space
    do_reset();
    rdy_mode = 2;
    pulse_start(19'h7FFFE);
    wait_done(200);
    chk("t4_reads", log_addr.size() >= 4, 1);
    if (log_addr.size() >= 4) begin
      chk("t4_addr0", log_addr[0], 19'h7FFFE);
      chk("t4_addr1", log_addr[1], 19'h7FFFF);
      chk("t4_addr2", log_addr[2], 19'h00000);
      chk("t4_addr3", log_addr[3], 19'h00001);
    end

    // start while busy ignored; reset mid-frame abandons the frame
    do_reset();
    rdy_mode = 2;
    pulse_start(19'h00300);
    repeat (3) @(posedge clk);
    pulse_start(19'h05555);
    wait_done(200);
    chk("t5_single_done", done_cnt, 1);
    pulse_start(19'h00400);
    repeat (5) @(posedge clk);
    #1; rst_n = 0;
    @(posedge clk); #1; rst_n = 1;
    clear_logs();
    repeat (30) @(posedge clk);
    chk("t5_no_done_after_abort", done_cnt, 0);
    chk("t5_no_reads_after_abort", rd_cnt, 0);
    chk("t5_idle_after_abort", busy_o, 0);
    pulse_start(19'h00040);
    wait_done(200);
    chk("t5_restart_done", done_cnt, 1);

    // Randomized frames with stray start pulses and random backpressure
    do_reset();
    rdy_mode = 2;
    for (int f = 0; f < 10; f++) begin
      pulse_start(AW'($urandom));
      seen = 0;
      n = 0;
      while (!seen && n < 400) begin
        @(posedge clk); #1;
        start_i = ($urandom_range(0, 7) == 0);
        base = AW'($urandom);
        @(negedge clk); #1;
        seen = done_o;
        n++;
      end
      start_i = 0;
      chk("t6_frame_done", seen, 1);
    end

`ifdef RAM_FRAME_READER_LOOP_EN
    // Continuous scan: done every NPIX pixels, busy never drops
    do_reset();
    rdy_mode = 1;
    pulse_start(19'h00010);
    for (int k = 0; k < 3; k++) wait_done(100);
    chk("t7_dones", done_cnt, 3);
    chk("t7_busy", busy_o, 1);
    for (int k = 0; k < 3; k++)
      if (k < pix_at_done.size()) chk("t7_pix_at_done", pix_at_done[k], 8 * (k + 1));
`endif

    do_reset();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
